// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree front end and tree wrappers.
// Holds default sizes, the loader state encoding and the feature bus slot indices.
package dtree_pkg;

    localparam int N_FEAT_DEFAULT = 7;
    localparam int FEAT_W_DEFAULT = 8;
    localparam int CLASS_W        = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

    // Slot of each tree input on the packed feature bus.
    localparam int FX6   = 0;
    localparam int FX13  = 1;
    localparam int FX169 = 2;
    localparam int FX236 = 3;
    localparam int FX251 = 4;
    localparam int FX260 = 5;
    localparam int FX278 = 6;

endpackage

// File: rtl/dtree_feature_regfile.sv
// N_FEAT x FEAT_W feature register file with one index-decoded write port.
// Every slot is presented in parallel on the flattened feat_o bus.
module dtree_feature_regfile
    import dtree_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEFAULT,
    parameter int FEAT_W = FEAT_W_DEFAULT,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [IDX_W-1:0]         widx,
    input  logic [FEAT_W-1:0]        wdata,
    output logic [N_FEAT*FEAT_W-1:0] feat_o
);

    logic [FEAT_W-1:0] regs_q [N_FEAT];
    logic [FEAT_W-1:0] regs_d [N_FEAT];

    always_comb begin
        for (int k = 0; k < N_FEAT; k++) begin
            regs_d[k] = regs_q[k];
            if (we && (widx == IDX_W'(k))) begin
                regs_d[k] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_FEAT; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_FEAT; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    for (genvar g = 0; g < N_FEAT; g++) begin : g_flat
        assign feat_o[g*FEAT_W +: FEAT_W] = regs_q[g];
    end

endmodule

// File: rtl/dtree_feature_loader.sv
// Byte-serial feature frame loader: assembles N_FEAT bytes and holds them for the tree.
// Optional trailing XOR check byte is built when DTREE_LOADER_CHECKSUM_EN is defined.
module dtree_feature_loader
    import dtree_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEFAULT,
    parameter int FEAT_W = FEAT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_first,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [N_FEAT*FEAT_W-1:0] feat_o,
    output logic                     feat_valid,
    input  logic                     feat_ready,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);

    // Handshake: a byte moves on a rising edge when s_valid && s_ready; the frame
    // is consumed on a rising edge when feat_valid && feat_ready. Neither ready
    // depends combinationally on the partner's valid.

    // One extra count so the index can point past the last feature at the check byte.
    localparam int IDX_W = $clog2(N_FEAT + 1);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              feat_valid_q, feat_valid_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              accept;

`ifdef DTREE_LOADER_CHECKSUM_EN
    logic [FEAT_W-1:0] csum_q, csum_d;
`endif

    assign s_ready = s_ready_q & rst_n;
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
`ifdef DTREE_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_first) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        idx_d   = IDX_W'(1);
                        state_d = LOAD;
`ifdef DTREE_LOADER_CHECKSUM_EN
                        csum_d  = s_data;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (s_first) begin
                        // Restart: older slots keep stale data and get overwritten later.
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        idx_d  = IDX_W'(1);
                        err_d  = 1'b1;
`ifdef DTREE_LOADER_CHECKSUM_EN
                        csum_d = s_data;
`endif
                    end else begin
`ifdef DTREE_LOADER_CHECKSUM_EN
                        if (idx_q == IDX_W'(N_FEAT)) begin
                            idx_d = '0;
                            if (s_data == csum_q) begin
                                state_d = HOLD;
                            end else begin
                                state_d = IDLE;
                                err_d   = 1'b1;
                            end
                        end else begin
                            wr_en  = 1'b1;
                            csum_d = csum_q ^ s_data;
                            idx_d  = idx_q + IDX_W'(1);
                        end
`else
                        wr_en = 1'b1;
                        if (idx_q == IDX_W'(N_FEAT - 1)) begin
                            idx_d   = '0;
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
`endif
                    end
                end
            end
            HOLD: begin
                if (feat_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Both readies are registered decodes of the next state.
        s_ready_d    = (state_d != HOLD);
        feat_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            s_ready_q    <= 1'b1;
            feat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            s_ready_q    <= s_ready_d;
            feat_valid_q <= feat_valid_d;
        end
    end

`ifdef DTREE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    dtree_feature_regfile #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .widx   (wr_idx),
        .wdata  (s_data),
        .feat_o (feat_o)
    );

    assign feat_valid = feat_valid_q;
    assign frame_err  = err_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader: nominal, backpressure, restart, orphan, reset, checksum.
// Define DTREE_LOADER_CHECKSUM_EN for both bench and RTL to exercise the check-byte build.
module tb_dtree_feature_loader;

    localparam int N_FEAT = 7;
    localparam int FEAT_W = 8;
    localparam int BUS_W  = N_FEAT * FEAT_W;

    logic              clk;
    logic              rst_n;
    logic [FEAT_W-1:0] s_data;
    logic              s_first;
    logic              s_valid;
    logic              s_ready;
    logic [BUS_W-1:0]  feat_o;
    logic              feat_valid;
    logic              feat_ready;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    int n_tests;
    int n_fail;

    dtree_feature_loader #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_first    (s_first),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .feat_o     (feat_o),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic send_byte(input logic [7:0] data, input logic first);
        int guard;
        s_valid = 1'b1;
        s_first = first;
        s_data  = data;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check("send_timeout", 64'd1, 64'd0);
        step();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_frame(input logic [BUS_W-1:0] f);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < N_FEAT; k++) begin
            send_byte(f[k*FEAT_W +: FEAT_W], k == 0);
            x = x ^ f[k*FEAT_W +: FEAT_W];
        end
`ifdef DTREE_LOADER_CHECKSUM_EN
        send_byte(x, 1'b0);
`endif
    endtask

    task automatic ack();
        feat_ready = 1'b1;
        step();
        feat_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        check("rst_s_ready", s_ready, 0);
        check("rst_feat_valid", feat_valid, 0);
        check("rst_feat_o", feat_o, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_s_ready", s_ready, 1);
    endtask

    logic [BUS_W-1:0] held;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        s_data     = '0;
        s_first    = 1'b0;
        s_valid    = 1'b0;
        feat_ready = 1'b0;
        step();
        do_reset();

        // Nominal frame
        send_frame(56'h77665544332211);
        check("nom_valid", feat_valid, 1);
        check("nom_feat_o", feat_o, 56'h77665544332211);
        check("nom_s_ready", s_ready, 0);
        check("nom_err", frame_err, 0);
        ack();
        check("nom_cnt", frame_cnt, 1);
        check("nom_s_ready_after", s_ready, 1);
        check("nom_valid_after", feat_valid, 0);

        // feat_ready without a held frame is ignored
        feat_ready = 1'b1;
        step();
        step();
        feat_ready = 1'b0;
        check("idle_ack_cnt", frame_cnt, 1);

        // Backpressure: upstream keeps offering while the frame is held
        send_frame(56'h87868584838281);
        held    = 56'h87868584838281;
        s_valid = 1'b1;
        s_first = 1'b1;
        s_data  = 8'hEE;
        for (int c = 0; c < 20; c++) begin
            step();
            check("bp_feat_o", feat_o, held);
            check("bp_valid", feat_valid, 1);
            check("bp_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        s_first = 1'b0;
        ack();
        check("bp_cnt", frame_cnt, 2);

        // Restart mid-frame
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check("rs_err_before", frame_err, 0);
        send_frame(56'hB6B5B4B3B2B1A0);
        check("rs_valid", feat_valid, 1);
        check("rs_byte0", feat_o[7:0], 8'hA0);
        check("rs_feat_o", feat_o, 56'hB6B5B4B3B2B1A0);
        check("rs_err", frame_err, 1);
        ack();
        check("rs_cnt", frame_cnt, 3);

        // Reset mid-frame
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        rst_n = 1'b0;
        step();
        check("mr_feat_o", feat_o, 0);
        check("mr_valid", feat_valid, 0);
        check("mr_err", frame_err, 0);
        check("mr_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        step();

        // Orphan byte in IDLE
        send_byte(8'h55, 1'b0);
        check("orph_err", frame_err, 1);
        check("orph_valid", feat_valid, 0);
        check("orph_feat_o", feat_o, 0);
        send_frame(56'h70605040302010);
        check("orph_frame_valid", feat_valid, 1);
        check("orph_frame_feat_o", feat_o, 56'h70605040302010);
        ack();
        check("orph_cnt", frame_cnt, 1);

`ifdef DTREE_LOADER_CHECKSUM_EN
        // Checksum: matching check byte delivers, mismatching one is dropped
        do_reset();
        send_frame(56'h07060504030201);
        check("cs_ok_valid", feat_valid, 1);
        check("cs_ok_feat_o", feat_o, 56'h07060504030201);
        check("cs_ok_err", frame_err, 0);
        ack();
        check("cs_ok_cnt", frame_cnt, 1);
        for (int k = 1; k <= N_FEAT; k++) begin
            send_byte(8'(k), k == 1);
        end
        send_byte(8'h08, 1'b0);
        check("cs_bad_valid", feat_valid, 0);
        check("cs_bad_err", frame_err, 1);
        check("cs_bad_s_ready", s_ready, 1);
        step();
        check("cs_bad_cnt", frame_cnt, 1);
        check("cs_bad_valid_late", feat_valid, 0);
`endif

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dtree_feature_loader.md
# dtree_feature_loader

Byte-serial front end for the printed decision-tree classifiers. Accepts one 8-bit feature per handshake from the sensor/ADC interface and assembles a complete feature frame in registers. Presents the frame as a parallel, stable bus to the downstream combinational tree (features X6, X13, X169, X236, X251, X260, X278, in that order) and holds it until the consumer acknowledges.

## Interface
Parameters:
- N_FEAT, 7, features per frame
- FEAT_W, 8, bits per feature

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_data  in  FEAT_W  incoming feature byte
- s_first  in  1  marks first byte of a frame; qualified by s_valid
- s_valid  in  1  upstream byte valid
- s_ready  out  1  loader can accept a byte this cycle
- feat_o  out  N_FEAT*FEAT_W  packed frame; feature k at bits [k*FEAT_W +: FEAT_W] (k=0 → X6 … k=6 → X278)
- feat_valid  out  1  feat_o holds a complete frame
- feat_ready  in  1  consumer has sampled feat_o / class result
- frame_err  out  1  sticky protocol/check error flag
- frame_cnt  out  16  count of frames delivered, wraps at 2^16

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE: s_ready=1. Accepted byte with s_first=1 → stored as feature 0, idx=1, go LOAD. Accepted byte with s_first=0 → discarded, frame_err set.
- LOAD: s_ready=1. Accepted byte stored at feature idx, idx++. The frame's final byte is the one at idx=N_FEAT-1, or the check byte when CHECKSUM_EN is defined; on accepting it → HOLD.
- s_first=1 while in LOAD: restart the frame. The byte becomes feature 0, idx=1, stay LOAD, and frame_err is set. Prior partial data is abandoned; stale registers are not cleared.
- HOLD: s_ready=0, feat_valid=1, feat_o stable. On feat_ready=1: go IDLE, frame_cnt++ (mod 2^16).
- Feature registers are written only in IDLE/LOAD. feat_o never changes while feat_valid=1.
- frame_err is cleared only by reset.
- Reset values: state IDLE, all feature registers 0, idx 0, feat_valid 0, frame_err 0, frame_cnt 0. s_ready=0 while rst_n=0.
- Reset mid-frame or in HOLD: all of the above restored on the next edge. The partial or held frame is lost, and frame_cnt is not incremented.

## Timing
- A byte transfers on a rising edge with s_valid && s_ready.
- s_ready is a registered decode of state (no combinational path from s_valid).
- feat_valid rises on the edge that accepts the final byte, so it is visible in the following cycle.
- feat_valid falls on the edge where feat_valid && feat_ready. s_ready is 1 in the cycle after.
- Minimum frame period: N_FEAT accept cycles + 1 HOLD cycle (8 cycles at defaults; 9 with CHECKSUM_EN).
- feat_ready while feat_valid=0 is ignored.

## Configuration
- Macro: DTREE_LOADER_CHECKSUM_EN.
- Defined:
  - Each frame carries one extra trailing byte equal to the XOR of its N_FEAT feature bytes.
  - A running XOR is kept in LOAD.
  - On a match → HOLD.
  - On a mismatch → IDLE, feat_valid stays 0, frame_err set, and frame_cnt is unchanged.
  - The check byte is never stored in feat_o.
- Undefined: frames are exactly N_FEAT bytes and no XOR logic is built. frame_err reports only the IDLE/LOAD s_first violations above.

## Structure
- Shared package dtree_pkg holds:
  - N_FEAT_DEFAULT=7, FEAT_W_DEFAULT=8, CLASS_W=5
  - the loader state enum {IDLE, LOAD, HOLD}
  - the feature index localparams (FX6=0 … FX278=6), which the tree wrappers reuse for bus slicing
- One natural sub-module, dtree_feature_regfile: N_FEAT×FEAT_W register file with write-enable and index-decoded write, all outputs flattened to feat_o.
- Control FSM, idx counter, checksum and frame_cnt live in the top.

## Test plan
- Nominal: after reset, send s_first=1 + bytes 0x11,0x22,…,0x77 back-to-back. feat_valid=1 in the cycle after the 7th accept, feat_o=0x77665544332211, s_ready=0. With feat_ready=1 one cycle later → frame_cnt=1, s_ready=1.
- Backpressure: hold feat_ready=0 for 20 cycles while s_valid=1. No byte is accepted, and feat_o is unchanged every cycle.
- Restart: send 3 bytes, then s_first=1 with 0xA0 followed by 6 bytes. feat_o[7:0]=0xA0, frame_err=1, frame delivered normally.
- Orphan byte: s_valid=1, s_first=0 in IDLE → byte dropped, frame_err=1, next s_first frame loads correctly.
- Reset mid-frame: rst_n=0 after 4 bytes → next cycle feat_o=0, feat_valid=0, frame_err=0, frame_cnt=0.
- CHECKSUM_EN: bytes 0x01..0x07 + check 0x00 → delivered. Same data + check 0x08 → no feat_valid, frame_err=1, frame_cnt unchanged.
